// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
//   Shared widths and constants for the register file / scoreboard slice.
//   RegAddrBus / RegDataBus : default address and data widths
//   NREG                    : number of architectural registers (reg 0 = 0)
//   RegAddr_0 / ZeroWord    : the zero register address and an all-zero word
//   Enable / Disable        : single-bit control levels
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

   localparam int RegAddrBus = 5;
   localparam int RegDataBus = 32;
   localparam int NREG       = 32;

   localparam logic [RegAddrBus-1:0] RegAddr_0 = '0;
   localparam logic [RegDataBus-1:0] ZeroWord  = '0;

   localparam logic Enable  = 1'b1;
   localparam logic Disable = 1'b0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// ---------------------------------------------------------------------------
// regfile_sb_rdport
//   One combinational read port: register select, optional writeback
//   forwarding and scoreboard busy qualification.
//   Build option: REGFILE_BYPASS_EN -- when defined, a same-cycle writeback
//   to the addressed register is forwarded to rdata and hides busy.
//
//   i/o summary
//     rst      in   forces rdata/busy to 0 while high
//     re       in   read enable
//     raddr    in   read address
//     regs     in   flattened register storage
//     busy_vec in   scoreboard bits
//     we/waddr/wdata in  writeback port (only used for forwarding)
//     rdata    out  read data
//     busy     out  source has a pending, not-yet-forwarded write
// ---------------------------------------------------------------------------
module regfile_sb_rdport
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W = RegDataBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int NR     = NREG
) (
   input  logic                     rst,
   input  logic                     re,
   input  logic [ADDR_W-1:0]        raddr,
   input  logic [NR-1:0][DATA_W-1:0] regs,
   input  logic [NR-1:0]            busy_vec,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy
);

   logic w_addr_nz;
   logic w_byp;

   assign w_addr_nz = (raddr != '0);

`ifdef REGFILE_BYPASS_EN
   assign w_byp = we & (waddr == raddr) & w_addr_nz;
`else
   // No forwarding: the writeback port is not observed by the read path.
   logic w_unused_byp;
   assign w_unused_byp = &{1'b0, we, waddr, wdata};
   assign w_byp        = Disable;
`endif

   always_comb begin
      rdata = '0;
      if (rst || !re || !w_addr_nz) rdata = '0;
      else if (w_byp)               rdata = wdata;
      else                          rdata = regs[raddr];
   end

   assign busy = ~rst & re & w_addr_nz & busy_vec[raddr] & ~w_byp;

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   General-purpose register file with per-register scoreboard.
//   Decode reserves a destination with sb_set; writeback releases it.
//   Reads are combinational; storage and scoreboard update on posedge clk.
//   Build option: REGFILE_BYPASS_EN (writeback -> read forwarding, see
//   regfile_sb_rdport).
//
//   i/o summary
//     clk, rst                  clock, synchronous active-high reset
//     we, waddr, wdata          writeback write port
//     re1/raddr1 -> rdata1      read port 1
//     re2/raddr2 -> rdata2      read port 2
//     sb_set, sb_addr           reserve destination at issue
//     sb_flush                  drop all reservations
//     busy1, busy2, stall_o     RAW hazard indication for decode
// ---------------------------------------------------------------------------
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W = RegDataBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int NREG   = regfile_sb_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   input  logic              sb_flush,
   output logic              busy1,
   output logic              busy2,
   output logic              stall_o
);

   logic [NREG-1:0][DATA_W-1:0] r_regs;
   logic [NREG-1:0]             r_busy;

   logic w_wr_ok;
   logic w_set_ok;

   assign w_wr_ok  = we     & (waddr   != '0);
   assign w_set_ok = sb_set & (sb_addr != '0);

   // Register storage; reg 0 is never written so it reads as zero.
   always_ff @(posedge clk) begin
      if (rst)          r_regs        <= '0;
      else if (w_wr_ok) r_regs[waddr] <= wdata;
   end

   // Scoreboard: the set is issued after the clear so that a newer
   // producer for the same register keeps it reserved.
   always_ff @(posedge clk) begin
      if (rst || sb_flush) begin
         r_busy <= '0;
      end else begin
         if (w_wr_ok)  r_busy[waddr]   <= Disable;
         if (w_set_ok) r_busy[sb_addr] <= Enable;
      end
   end

   regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NREG)) u_rd1 (
      .rst      (rst),
      .re       (re1),
      .raddr    (raddr1),
      .regs     (r_regs),
      .busy_vec (r_busy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata1),
      .busy     (busy1)
   );

   regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NREG)) u_rd2 (
      .rst      (rst),
      .re       (re2),
      .raddr    (raddr2),
      .regs     (r_regs),
      .busy_vec (r_busy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata2),
      .busy     (busy2)
   );

   assign stall_o = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst, we, re1, re2, sb_set, sb_flush;
   logic [4:0]  waddr, raddr1, raddr2, sb_addr;
   logic [31:0] wdata, rdata1, rdata2;
   logic        busy1, busy2, stall_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic        b1;
      logic        b2;
      logic        st;
   } exp_t;

   exp_t q[$];
   exp_t e;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
      .busy1(busy1), .busy2(busy2), .stall_o(stall_o)
   );

   task automatic idle();
      we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
      sb_set = 0; sb_addr = 0; sb_flush = 0;
   endtask

   // advance one edge; inputs change 1 time unit after posedge
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [31:0] r1, input logic [31:0] r2,
                       input logic b1, input logic b2, input logic st);
      exp_t x;
      x.r1 = r1; x.r2 = r2; x.b1 = b1; x.b2 = b2; x.st = st;
      q.push_back(x);
   endtask

   task automatic test_reset();
      rst = 1; idle(); step();
      rst = 0;
      we = 1; waddr = 5; wdata = 32'h1234; sb_set = 1; sb_addr = 5;
      step();
      idle(); re1 = 1; raddr1 = 5;
      push(32'h1234, 0, 1, 0, 1);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL pre_reset_rdata got %h want %h", rdata1, e.r1); end
      checks++; if (busy1 !== e.b1) begin errors++; $display("FAIL pre_reset_busy got %b want %b", busy1, e.b1); end
      rst = 1;
      push(0, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL in_reset_rdata got %h want %h", rdata1, e.r1); end
      checks++; if ({busy1, stall_o} !== {e.b1, e.st}) begin errors++; $display("FAIL in_reset_busy got %b%b want %b%b", busy1, stall_o, e.b1, e.st); end
      step();
      rst = 0;
      push(0, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL post_reset_rdata got %h want %h", rdata1, e.r1); end
      checks++; if (busy1 !== e.b1) begin errors++; $display("FAIL post_reset_busy got %b want %b", busy1, e.b1); end
   endtask

   task automatic test_reg0();
      idle();
      we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; sb_set = 1; sb_addr = 0;
      re1 = 1; raddr1 = 0;
      push(0, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL reg0_same_cycle got %h want %h", rdata1, e.r1); end
      step();
      idle(); re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
      push(0, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL reg0_read got %h/%h want %h/%h", rdata1, rdata2, e.r1, e.r2); end
      checks++; if ({busy1, busy2, stall_o} !== {e.b1, e.b2, e.st}) begin errors++; $display("FAIL reg0_busy got %b%b%b want 000", busy1, busy2, stall_o); end
   endtask

   task automatic test_write_read();
      idle();
      we = 1; waddr = 7; wdata = 32'hDEAD_BEEF;
      re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
      push(BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL wr_same_cycle got %h/%h want %h/%h", rdata1, rdata2, e.r1, e.r2); end
      step();
      we = 0;
      push(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL wr_next_cycle got %h/%h want %h/%h", rdata1, rdata2, e.r1, e.r2); end
      re1 = 0;
      push(0, 32'hDEAD_BEEF, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL re1_off got %h/%h want %h/%h", rdata1, rdata2, e.r1, e.r2); end
   endtask

   task automatic test_scoreboard();
      idle();
      sb_set = 1; sb_addr = 9; re1 = 1; raddr1 = 9;
      push(0, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if (busy1 !== e.b1) begin errors++; $display("FAIL sb_set_same_cycle got %b want %b", busy1, e.b1); end
      step();
      sb_set = 0;
      push(0, 0, 1, 0, 1);
      #2 e = q.pop_front();
      checks++; if ({busy1, stall_o} !== {e.b1, e.st}) begin errors++; $display("FAIL sb_busy got %b%b want %b%b", busy1, stall_o, e.b1, e.st); end
      we = 1; waddr = 9; wdata = 32'h55;
      push(BYP ? 32'h55 : 32'h0, 0, !BYP, 0, !BYP);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL wb_cycle_rdata got %h want %h", rdata1, e.r1); end
      checks++; if ({busy1, stall_o} !== {e.b1, e.st}) begin errors++; $display("FAIL wb_cycle_busy got %b%b want %b%b", busy1, stall_o, e.b1, e.st); end
      step();
      we = 0;
      push(32'h55, 0, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if (rdata1 !== e.r1) begin errors++; $display("FAIL after_wb_rdata got %h want %h", rdata1, e.r1); end
      checks++; if ({busy1, stall_o} !== {e.b1, e.st}) begin errors++; $display("FAIL after_wb_busy got %b%b want 00", busy1, stall_o); end
   endtask

   task automatic test_set_clear();
      idle();
      sb_set = 1; sb_addr = 3;
      step();
      idle(); re2 = 1; raddr2 = 3;
      push(0, 0, 0, 1, 1);
      #2 e = q.pop_front();
      checks++; if ({busy2, stall_o} !== {e.b2, e.st}) begin errors++; $display("FAIL b3_set got %b%b want %b%b", busy2, stall_o, e.b2, e.st); end
      we = 1; waddr = 3; wdata = 32'hA5A5_0003; sb_set = 1; sb_addr = 3;
      step();
      we = 0; sb_set = 0;
      push(0, 32'hA5A5_0003, 0, 1, 1);
      #2 e = q.pop_front();
      checks++; if (busy2 !== e.b2) begin errors++; $display("FAIL set_wins got %b want %b", busy2, e.b2); end
      checks++; if (rdata2 !== e.r2) begin errors++; $display("FAIL set_clear_data got %h want %h", rdata2, e.r2); end
      we = 1; waddr = 3; wdata = 32'hA5A5_0033;
      step();
      we = 0;
      push(0, 32'hA5A5_0033, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata2, busy2} !== {e.r2, e.b2}) begin errors++; $display("FAIL b3_release got %h/%b want %h/%b", rdata2, busy2, e.r2, e.b2); end
   endtask

   task automatic test_flush();
      logic [4:0] addrs [4];
      addrs[0] = 4; addrs[1] = 10; addrs[2] = 31; addrs[3] = 12;
      idle();
      for (int i = 0; i < 3; i++) begin
         sb_set = 1; sb_addr = addrs[i]; step();
      end
      idle(); re1 = 1; raddr1 = 31; re2 = 1; raddr2 = 4;
      push(0, 0, 1, 1, 1);
      #2 e = q.pop_front();
      checks++; if ({busy1, busy2, stall_o} !== {e.b1, e.b2, e.st}) begin errors++; $display("FAIL pre_flush got %b%b%b want 111", busy1, busy2, stall_o); end
      sb_flush = 1; sb_set = 1; sb_addr = 12;
      step();
      sb_flush = 0; sb_set = 0;
      for (int i = 0; i < 4; i++) begin
         raddr1 = addrs[i]; raddr2 = addrs[3 - i];
         push(0, 0, 0, 0, 0);
         #2 e = q.pop_front();
         checks++; if ({busy1, busy2, stall_o} !== {e.b1, e.b2, e.st}) begin errors++; $display("FAIL flush_r%0d got %b%b%b want 000", addrs[i], busy1, busy2, stall_o); end
      end
   endtask

   task automatic test_back_to_back();
      idle();
      re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 9;
      push(32'hDEAD_BEEF, 32'h55, 0, 0, 0);
      #2 e = q.pop_front();
      checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL indep_ports got %h/%h want %h/%h", rdata1, rdata2, e.r1, e.r2); end
      // consecutive writebacks to distinct registers, read back afterward
      for (int i = 0; i < 4; i++) begin
         we = 1; waddr = 5'(16 + i); wdata = 32'hC0DE_0000 + i; step();
      end
      we = 0;
      for (int i = 0; i < 4; i += 2) begin
         raddr1 = 5'(16 + i); raddr2 = 5'(17 + i);
         push(32'hC0DE_0000 + i, 32'hC0DE_0001 + i, 0, 0, 0);
         #2 e = q.pop_front();
         checks++; if ({rdata1, rdata2} !== {e.r1, e.r2}) begin errors++; $display("FAIL b2b_r%0d got %h/%h want %h/%h", 16 + i, rdata1, rdata2, e.r1, e.r2); end
      end
   endtask

   initial begin
      rst = 1; idle();
      #1;
      test_reset();
      test_reg0();
      test_write_read();
      test_scoreboard();
      test_set_clear();
      test_flush();
      test_back_to_back();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
